// File: rtl/seg7_scan_display.sv
// Four-digit multiplexed seven-segment driver for the keypad lock: scans a frame-latched
// copy of the entry word and try count, with anti-ghost blanking and lockout blinking.
module seg7_scan_display #(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_CYCLES = 25000000,
  parameter int LOCK_TRIES   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] digits,
  input  logic [4:0]  tries,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        frame_tick
);

  localparam int SW = $clog2(SLOT_CYCLES);
  localparam int BW = $clog2(BLINK_CYCLES);

  logic [SW-1:0] slot_cnt_reg;
  logic [1:0]    dig_idx_reg;
  logic [BW-1:0] blink_cnt_reg;
  logic          blink_on_reg;
  logic [11:0]   shadow_digits_reg;
  logic [4:0]    shadow_tries_reg;
  logic          first_reg;
  logic [3:0]    an_reg, an_next;
  logic [7:0]    seg_reg, seg_next;
  logic          frame_tick_reg;

  logic          slot_wrap;
  logic          frame_load;
  logic          lock;
  logic [4:0]    code;
  logic [3:0]    nib [4];

  // Code 5'h10 is the 'P' glyph; 0..15 follow the nibble table.
  function automatic logic [7:0] seg_decode(input logic [4:0] c);
    case (c)
      5'h00: seg_decode = 8'hC0;
      5'h01: seg_decode = 8'hF9;
      5'h02: seg_decode = 8'hA4;
      5'h03: seg_decode = 8'hB0;
      5'h04: seg_decode = 8'h99;
      5'h05: seg_decode = 8'h92;
      5'h06: seg_decode = 8'h82;
      5'h07: seg_decode = 8'hF8;
      5'h08: seg_decode = 8'h80;
      5'h09: seg_decode = 8'h90;
      5'h0A, 5'h0D, 5'h0E: seg_decode = 8'hBF;
      5'h0B: seg_decode = 8'h88;
      5'h0C: seg_decode = 8'h92;
      5'h10: seg_decode = 8'h8C;
      default: seg_decode = 8'hFF;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_nib
      assign nib[gi] = shadow_digits_reg[4*gi +: 4];
    end
  endgenerate
  assign nib[3] = 4'hF;

  assign slot_wrap  = (slot_cnt_reg == SW'(SLOT_CYCLES - 1));
  assign frame_load = first_reg | (slot_wrap & (dig_idx_reg == 2'd3));
  assign lock       = (shadow_digits_reg == 12'h000) && (shadow_tries_reg >= 5'(LOCK_TRIES));

  always_comb begin
    code = {1'b0, nib[dig_idx_reg]};
    if (dig_idx_reg == 2'd3) begin
      if (shadow_digits_reg == 12'hBCC)   code = 5'h10;
      else if (shadow_tries_reg == 5'd0)  code = 5'h0F;
      else if (shadow_tries_reg < 5'd10)  code = shadow_tries_reg;
      else                                code = 5'h0A;
    end
  end

  // The cycle right after reset only latches the frame, so it is always dark.
  always_comb begin
    an_next  = 4'b1111;
    seg_next = 8'hFF;
    if (!first_reg && (slot_cnt_reg >= SW'(BLANK_CYCLES)) && !(lock && !blink_on_reg)) begin
      an_next  = ~(4'b0001 << dig_idx_reg);
      seg_next = seg_decode(code);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_reg      <= '0;
      dig_idx_reg       <= 2'd0;
      blink_cnt_reg     <= '0;
      blink_on_reg      <= 1'b1;
      shadow_digits_reg <= 12'hFFF;
      shadow_tries_reg  <= 5'd0;
      first_reg         <= 1'b1;
      an_reg            <= 4'b1111;
      seg_reg           <= 8'hFF;
      frame_tick_reg    <= 1'b0;
    end else begin
      first_reg      <= 1'b0;
      an_reg         <= an_next;
      seg_reg        <= seg_next;
      frame_tick_reg <= frame_load;
      if (frame_load) begin
        shadow_digits_reg <= digits;
        shadow_tries_reg  <= tries;
      end
      // Counters stay parked at slot 0 / digit 0 through the post-reset latch cycle.
      if (!first_reg) begin
        if (slot_wrap) begin
          slot_cnt_reg <= '0;
          dig_idx_reg  <= dig_idx_reg + 2'd1;
        end else begin
          slot_cnt_reg <= slot_cnt_reg + SW'(1);
        end
      end
      if (!lock) begin
        blink_cnt_reg <= '0;
        blink_on_reg  <= 1'b1;
      end else if (blink_cnt_reg == BW'(BLINK_CYCLES - 1)) begin
        blink_cnt_reg <= '0;
        blink_on_reg  <= ~blink_on_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + BW'(1);
      end
    end
  end

  assign an         = an_reg;
  assign seg        = seg_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display: per-cycle comparison against a cycle-count
// based display model, plus directed checks on reset, pass glyph, tearing and lockout.
module tb_seg7_scan_display;

  localparam int S  = 8;
  localparam int BL = 2;
  localparam int BK = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] digits = 12'h000;
  logic [4:0]  tries = 5'd0;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_tick;

  int total = 0;
  int bad   = 0;

  seg7_scan_display #(
    .SLOT_CYCLES(S), .BLANK_CYCLES(BL), .BLINK_CYCLES(BK), .LOCK_TRIES(6)
  ) dut (
    .clk(clk), .rst(rst), .digits(digits), .tries(tries),
    .an(an), .seg(seg), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Glyph table for nibble values 0..F.
  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'hBF, 8'h88, 8'h92, 8'hBF, 8'hBF, 8'hFF};

  // Reference model: everything follows from m_t, the number of clocks since reset release.
  int          m_t;
  logic [11:0] sh_d;
  int          sh_t;
  int          lock_run;
  int          pos, sc, dg;
  bit          m_lock, m_on;
  logic [3:0]  exp_an;
  logic [7:0]  exp_seg;
  logic        exp_ft;

  always @(posedge clk) begin
    if (rst) begin
      exp_an = 4'hF; exp_seg = 8'hFF; exp_ft = 1'b0;
      m_t = 0; sh_d = 12'hFFF; sh_t = 0; lock_run = 0;
    end else begin
      m_lock  = (sh_d == 12'h000) && (sh_t >= 6);
      m_on    = !m_lock || (((lock_run / BK) % 2) == 0);
      exp_an  = 4'hF;
      exp_seg = 8'hFF;
      if (m_t > 0) begin
        pos = m_t - 1;
        sc  = pos % S;
        dg  = (pos / S) % 4;
        if (sc >= BL && m_on) begin
          exp_an = 4'hF ^ (4'h1 << dg);
          if (dg < 3)               exp_seg = hex_tab[(sh_d >> (4 * dg)) & 12'hF];
          else if (sh_d == 12'hBCC) exp_seg = 8'h8C;
          else if (sh_t == 0)       exp_seg = 8'hFF;
          else if (sh_t <= 9)       exp_seg = hex_tab[sh_t];
          else                      exp_seg = 8'hBF;
        end
      end
      exp_ft   = ((m_t % (4 * S)) == 0);
      lock_run = m_lock ? lock_run + 1 : 0;
      if (exp_ft) begin
        sh_d = digits;
        sh_t = int'(tries);
      end
      m_t++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; digits = 12'h246; tries = 5'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (an !== 4'hF || seg !== 8'hFF || frame_tick !== 1'b0) begin
        bad++;
        $display("FAIL reset_state cyc=%0d got an=%b seg=%h ft=%b want an=1111 seg=ff ft=0", i, an, seg, frame_tick);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      total++;
      if ({an, seg, frame_tick} !== {exp_an, exp_seg, exp_ft}) begin
        bad++;
        $display("FAIL reset_scan cyc=%0d got an=%b seg=%h ft=%b want an=%b seg=%h ft=%b", i, an, seg, frame_tick, exp_an, exp_seg, exp_ft);
      end
      if (i == 0) begin
        total++;
        if (frame_tick !== 1'b1) begin
          bad++;
          $display("FAIL release_tick got ft=%b want ft=1", frame_tick);
        end
      end
    end
    $display("test_reset: digits=246 tries=0 done");
  endtask

  task automatic test_pass();
    bit seen_p = 0;
    digits = 12'hBCC; tries = 5'd2;
    for (int i = 0; i < 100; i++) begin
      step();
      total++;
      if ({an, seg, frame_tick} !== {exp_an, exp_seg, exp_ft}) begin
        bad++;
        $display("FAIL pass_scan cyc=%0d got an=%b seg=%h ft=%b want an=%b seg=%h ft=%b", i, an, seg, frame_tick, exp_an, exp_seg, exp_ft);
      end
      if (an == 4'b0111 && seg == 8'h8C) seen_p = 1;
    end
    total++;
    if (!seen_p) begin
      bad++;
      $display("FAIL pass_glyph got no P on digit3 want an=0111 seg=8c");
    end
    $display("test_pass: digits=bcc tries=2 done");
  endtask

  task automatic test_no_tear();
    bit found = 0;
    digits = 12'h123; tries = 5'd0;
    for (int i = 0; i < 140 && !found; i++) begin
      step();
      total++;
      if ({an, seg, frame_tick} !== {exp_an, exp_seg, exp_ft}) begin
        bad++;
        $display("FAIL tear_pre cyc=%0d got an=%b seg=%h ft=%b want an=%b seg=%h ft=%b", i, an, seg, frame_tick, exp_an, exp_seg, exp_ft);
      end
      if (i > 40 && an == 4'b1101) found = 1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL tear_wait got no digit1 slot within budget want an=1101");
    end
    digits = 12'h789;
    for (int i = 0; i < 80; i++) begin
      step();
      total++;
      if ({an, seg, frame_tick} !== {exp_an, exp_seg, exp_ft}) begin
        bad++;
        $display("FAIL tear_post cyc=%0d got an=%b seg=%h ft=%b want an=%b seg=%h ft=%b", i, an, seg, frame_tick, exp_an, exp_seg, exp_ft);
      end
    end
    $display("test_no_tear: 123 -> 789 mid-frame done");
  endtask

  task automatic test_lockout();
    int run = 0, max_run = 0;
    digits = 12'h000; tries = 5'd6;
    for (int i = 0; i < 260; i++) begin
      step();
      total++;
      if ({an, seg, frame_tick} !== {exp_an, exp_seg, exp_ft}) begin
        bad++;
        $display("FAIL lock_scan cyc=%0d got an=%b seg=%h ft=%b want an=%b seg=%h ft=%b", i, an, seg, frame_tick, exp_an, exp_seg, exp_ft);
      end
      run = (an == 4'hF) ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    total++;
    if (max_run < BK) begin
      bad++;
      $display("FAIL lock_dark got longest dark run=%0d want >=%0d", max_run, BK);
    end
    tries = 5'd0;
    run = 0; max_run = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      total++;
      if ({an, seg, frame_tick} !== {exp_an, exp_seg, exp_ft}) begin
        bad++;
        $display("FAIL unlock_scan cyc=%0d got an=%b seg=%h ft=%b want an=%b seg=%h ft=%b", i, an, seg, frame_tick, exp_an, exp_seg, exp_ft);
      end
      run = (an == 4'hF) ? run + 1 : 0;
      if (i >= 40 && run > max_run) max_run = run;
    end
    total++;
    if (max_run > BL) begin
      bad++;
      $display("FAIL unlock_steady got longest dark run=%0d want <=%0d", max_run, BL);
    end
    $display("test_lockout: 000/6 blink then tries=0 done");
  endtask

  task automatic test_dash();
    bit seen_dash = 0;
    digits = 12'hFFF; tries = 5'd12;
    for (int i = 0; i < 100; i++) begin
      step();
      total++;
      if ({an, seg, frame_tick} !== {exp_an, exp_seg, exp_ft}) begin
        bad++;
        $display("FAIL dash_scan cyc=%0d got an=%b seg=%h ft=%b want an=%b seg=%h ft=%b", i, an, seg, frame_tick, exp_an, exp_seg, exp_ft);
      end
      if (an == 4'b0111 && seg == 8'hBF) seen_dash = 1;
    end
    total++;
    if (!seen_dash) begin
      bad++;
      $display("FAIL dash_glyph got no dash on digit3 want an=0111 seg=bf");
    end
    $display("test_dash: fff/12 done");
  endtask

  task automatic test_random();
    int n;
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 3))
        0:       digits = 12'h000;
        1:       digits = 12'hBCC;
        default: digits = 12'($urandom);
      endcase
      tries = 5'($urandom_range(0, 31));
      n = $urandom_range(5, 70);
      for (int i = 0; i < n; i++) begin
        step();
        total++;
        if ({an, seg, frame_tick} !== {exp_an, exp_seg, exp_ft}) begin
          bad++;
          $display("FAIL random_scan k=%0d cyc=%0d got an=%b seg=%h ft=%b want an=%b seg=%h ft=%b", k, i, an, seg, frame_tick, exp_an, exp_seg, exp_ft);
        end
      end
      $display("test_random: k=%0d digits=%h tries=%0d cycles=%0d", k, digits, tries, n);
    end
  endtask

  task automatic test_midreset();
    bit found = 0;
    digits = 12'h135; tries = 5'd3;
    for (int i = 0; i < 140 && !found; i++) begin
      step();
      if (i > 40 && an == 4'b1011) found = 1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL midreset_wait got no digit2 slot within budget want an=1011");
    end
    rst = 1'b1;
    step();
    total++;
    if (an !== 4'hF || seg !== 8'hFF || frame_tick !== 1'b0) begin
      bad++;
      $display("FAIL midreset_abort got an=%b seg=%h ft=%b want an=1111 seg=ff ft=0", an, seg, frame_tick);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      total++;
      if ({an, seg, frame_tick} !== {exp_an, exp_seg, exp_ft}) begin
        bad++;
        $display("FAIL midreset_scan cyc=%0d got an=%b seg=%h ft=%b want an=%b seg=%h ft=%b", i, an, seg, frame_tick, exp_an, exp_seg, exp_ft);
      end
      if (i == 0) begin
        total++;
        if (frame_tick !== 1'b1) begin
          bad++;
          $display("FAIL midreset_tick got ft=%b want ft=1", frame_tick);
        end
      end
    end
    $display("test_midreset: abort at digit2 and restart done");
  endtask

  initial begin
    test_reset();
    test_pass();
    test_no_tear();
    test_lockout();
    test_dash();
    test_random();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
